// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: fetch PC, imem handshake and F/D register.
// One request outstanding at most; a single hold slot absorbs responses during decode stalls.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_f_stall,
   input  logic        i_fd_stall,
   input  logic        i_fd_flush,
   input  logic        i_e_mux_pc_src,
   input  logic [31:0] i_e_pc_target,
   output logic        o_imem_req_valid,
   output logic [31:0] o_imem_req_addr,
   input  logic        i_imem_req_ready,
   input  logic        i_imem_resp_valid,
   input  logic [31:0] i_imem_resp_data,
   output logic [31:0] o_d_instr,
   output logic [31:0] o_d_pc,
   output logic [31:0] o_d_pc_plus4,
   output logic        o_d_valid
);

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_DROP = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] dpc_q, dpc_d;
   logic [31:0] dpc4_q, dpc4_d;
   logic        dval_q, dval_d;

   logic        redirect;
   logic        resp_w;
   logic        avail;
   logic        deliver;
   logic        accept;
   logic [31:0] pc_plus4;
   logic [31:0] instr_av;
   logic [31:0] tgt_al;
   logic        unused_tgt;

   assign redirect   = i_e_mux_pc_src;
   assign tgt_al     = {i_e_pc_target[31:2], 2'b00};
   assign unused_tgt = ^i_e_pc_target[1:0];
   assign pc_plus4   = pc_q + 32'd4;
   assign resp_w     = (state_q == S_WAIT) & i_imem_resp_valid;
   assign avail      = resp_w | (state_q == S_HOLD);
   assign deliver    = avail & ~i_fd_stall & ~i_fd_flush & ~redirect;
   assign instr_av   = (state_q == S_HOLD) ? hold_q : i_imem_resp_data;

   // WAIT issues the next word in the same cycle it hands one to decode
   assign o_imem_req_valid = ~i_reset & ~i_f_stall &
                             ((state_q == S_REQ) | (resp_w & deliver));
   assign o_imem_req_addr  = (state_q == S_REQ) ? pc_q : pc_plus4;
   assign accept           = o_imem_req_valid & i_imem_req_ready;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      unique case (state_q)
         S_REQ: begin
            // a request accepted while being redirected is stale on return
            if (accept) state_d = redirect ? S_DROP : S_WAIT;
         end
         S_WAIT: begin
            if (redirect) begin
               state_d = i_imem_resp_valid ? S_REQ : S_DROP;
            end else if (i_imem_resp_valid) begin
               if (deliver) begin
                  state_d = accept ? S_WAIT : S_REQ;
               end else begin
                  hold_d  = i_imem_resp_data;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (redirect | deliver) state_d = S_REQ;
         end
         S_DROP: begin
            if (i_imem_resp_valid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      if (redirect)     pc_d = tgt_al;
      else if (deliver) pc_d = pc_plus4;
   end

   always_comb begin
      instr_d = instr_q;
      dpc_d   = dpc_q;
      dpc4_d  = dpc4_q;
      dval_d  = dval_q;
      if (i_fd_flush | redirect) begin
         instr_d = NOP_INSTR;
         dval_d  = 1'b0;
      end else if (i_fd_stall) begin
         dval_d  = dval_q;
      end else if (deliver) begin
         instr_d = instr_av;
         dpc_d   = pc_q;
         dpc4_d  = pc_plus4;
         dval_d  = 1'b1;
      end else begin
         instr_d = NOP_INSTR;
         dval_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         hold_q  <= NOP_INSTR;
         instr_q <= NOP_INSTR;
         dpc_q   <= 32'd0;
         dpc4_q  <= 32'd0;
         dval_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         instr_q <= instr_d;
         dpc_q   <= dpc_d;
         dpc4_q  <= dpc4_d;
         dval_q  <= dval_d;
      end
   end

   assign o_d_instr    = instr_q;
   assign o_d_pc       = dpc_q;
   assign o_d_pc_plus4 = dpc4_q;
   assign o_d_valid    = dval_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model, program-order scoreboard and
// directed plus randomized hazard stimulus.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        f_stall = 1'b0;
   logic        fd_stall = 1'b0;
   logic        fd_flush = 1'b0;
   logic        pc_src = 1'b0;
   logic [31:0] tgt = 32'd0;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        ready = 1'b1;
   logic        resp_valid = 1'b0;
   logic [31:0] resp_data = 32'd0;
   logic [31:0] d_instr;
   logic [31:0] d_pc;
   logic [31:0] d_pc4;
   logic        d_valid;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .i_clk             (clk),
      .i_reset           (reset),
      .i_f_stall         (f_stall),
      .i_fd_stall        (fd_stall),
      .i_fd_flush        (fd_flush),
      .i_e_mux_pc_src    (pc_src),
      .i_e_pc_target     (tgt),
      .o_imem_req_valid  (req_valid),
      .o_imem_req_addr   (req_addr),
      .i_imem_req_ready  (ready),
      .i_imem_resp_valid (resp_valid),
      .i_imem_resp_data  (resp_data),
      .o_d_instr         (d_instr),
      .o_d_pc            (d_pc),
      .o_d_pc_plus4      (d_pc4),
      .o_d_valid         (d_valid)
   );

   int tests = 0;
   int fails = 0;
   int delivered = 0;

   // expected program-order fetch stream
   logic [31:0] q[$];
   logic [31:0] nxt = 32'd0;

   // memory model
   bit          pend = 1'b0;
   int          cnt = 0;
   logic [31:0] paddr = 32'd0;
   bit          force_resp = 1'b0;
   int          lat_lo = 1;
   int          lat_hi = 1;

   bit          s_acc;
   bit          s_rv;
   logic [31:0] s_addr;
   bit          p_wait = 1'b0;
   bit          p_rdr = 1'b0;
   logic [31:0] p_addr = 32'd0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_instr"}, d_instr, NOP);
      chk({nm, "_pc"}, d_pc, 32'd0);
      chk({nm, "_pc4"}, d_pc4, 32'd0);
      chk({nm, "_valid"}, {31'd0, d_valid}, 32'd0);
   endtask

   // one clock: called at a negedge, returns at the next negedge
   task automatic cyc(input bit rst, input bit fs, input bit fds,
                      input bit rdr, input logic [31:0] t, input bit rdy);
      bit mem_rv;
      reset    = rst;
      f_stall  = fs;
      fd_stall = fds;
      fd_flush = rdr;
      pc_src   = rdr;
      tgt      = t;
      ready    = rdy;
      mem_rv     = pend && (cnt == 0);
      resp_valid = mem_rv | force_resp;
      resp_data  = force_resp ? 32'hDEAD_BEEF : (paddr ^ 32'hA5);
      if (rst) begin
         q.delete();
         nxt = 32'd0;
      end else if (rdr) begin
         q.delete();
         nxt = {t[31:2], 2'b00};
      end
      while (q.size() < 8) begin
         q.push_back(nxt);
         nxt = nxt + 32'd4;
      end
      #1;
      s_rv   = req_valid;
      s_addr = req_addr;
      s_acc  = req_valid && ready;
      if (rst) begin
         chk("req_valid_in_reset", {31'd0, req_valid}, 32'd0);
      end else if (req_valid) begin
         chk("req_align", {30'd0, req_addr[1:0]}, 32'd0);
         if (p_wait && !p_rdr) chk("req_addr_stable", req_addr, p_addr);
      end
      if (mem_rv) pend = 1'b0;
      else if (pend) cnt--;
      if (s_acc) begin
         tests++;
         if (pend) begin
            fails++;
            $display("FAIL one_outstanding: second request %h accepted while %h pending",
                     req_addr, paddr);
         end
         pend  = 1'b1;
         cnt   = int'($urandom_range(lat_hi, lat_lo)) - 1;
         paddr = req_addr;
      end
      if (rst) pend = 1'b0;
      force_resp = 1'b0;
      p_wait = !rst && req_valid && !ready;
      p_rdr  = rdr;
      p_addr = req_addr;
      @(negedge clk);
   endtask

   task automatic go();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
   endtask

   task automatic do_reset(input int lo, input int hi);
      lat_lo = lo;
      lat_hi = hi;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
   endtask

   // monitor: every new F/D instruction must be the next program-order word
   initial begin
      bit st;
      bit rs;
      logic [31:0] e;
      forever begin
         @(posedge clk);
         st = fd_stall;
         rs = reset;
         #1;
         if (!rs && !st && d_valid) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL scoreboard_empty: got pc %h expected no delivery", d_pc);
            end else begin
               e = q.pop_front();
               chk("d_pc", d_pc, e);
               chk("d_instr", d_instr, e ^ 32'hA5);
               chk("d_pc_plus4", d_pc4, e + 32'd4);
               delivered++;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit found;
      int base;
      int r;
      logic [31:0] t;
      @(negedge clk);

      // streaming with a 1-cycle memory
      do_reset(1, 1);
      chk_reset_outs("rst1");
      for (int i = 0; i < 6; i++) begin
         go();
         chk("t1_req_valid", {31'd0, s_rv}, 32'd1);
         chk("t1_req_addr", s_addr, 32'(4 * i));
         if (i == 0) begin
            chk("t1_first_valid", {31'd0, d_valid}, 32'd0);
         end else begin
            chk("t1_valid", {31'd0, d_valid}, 32'd1);
            chk("t1_pc", d_pc, 32'(4 * (i - 1)));
            chk("t1_pc4", d_pc4, 32'(4 * i));
         end
      end

      // decode stall while the 0x8 response arrives
      do_reset(1, 1);
      for (int i = 0; i < 3; i++) go();
      chk("t2_pre_pc", d_pc, 32'h4);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
         chk("t2_no_req", {31'd0, s_rv}, 32'd0);
         chk("t2_hold_pc", d_pc, 32'h4);
         chk("t2_hold_valid", {31'd0, d_valid}, 32'd1);
      end
      go();
      chk("t2_hold_no_req", {31'd0, s_rv}, 32'd0);
      chk("t2_rel_pc", d_pc, 32'h8);
      chk("t2_rel_valid", {31'd0, d_valid}, 32'd1);
      go();
      chk("t2_next_req", {31'd0, s_rv}, 32'd1);
      chk("t2_next_addr", s_addr, 32'hC);

      // redirect while a slow response is outstanding
      do_reset(3, 3);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         go();
         if (s_acc && s_addr == 32'h10) found = 1'b1;
      end
      chk("t3_found_0x10", {31'd0, found}, 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
      chk("t3_redir_valid", {31'd0, d_valid}, 32'd0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         go();
         if (s_rv) found = 1'b1;
      end
      chk("t3_req_seen", {31'd0, found}, 32'd1);
      chk("t3_req_addr", s_addr, 32'h100);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         go();
         if (d_valid) found = 1'b1;
      end
      chk("t3_deliver_seen", {31'd0, found}, 32'd1);
      chk("t3_pc", d_pc, 32'h100);

      // redirect coinciding with the response
      do_reset(1, 1);
      go();
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
      chk("t4_no_req", {31'd0, s_rv}, 32'd0);
      chk("t4_valid", {31'd0, d_valid}, 32'd0);
      go();
      chk("t4_req_valid", {31'd0, s_rv}, 32'd1);
      chk("t4_req_addr", s_addr, 32'h200);
      go();
      chk("t4_pc", d_pc, 32'h200);

      // memory not ready at 0x20
      do_reset(1, 1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         go();
         if (d_valid && d_pc == 32'h18) found = 1'b1;
      end
      chk("t5_found_0x18", {31'd0, found}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
         chk("t5_req_valid", {31'd0, s_rv}, 32'd1);
         chk("t5_req_addr", s_addr, 32'h20);
         if (i > 0) begin
            chk("t5_bubble_valid", {31'd0, d_valid}, 32'd0);
            chk("t5_bubble_instr", d_instr, NOP);
         end
      end
      go();
      chk("t5_accept", {31'd0, s_acc}, 32'd1);
      chk("t5_accept_addr", s_addr, 32'h20);

      // reset in WAIT followed by a stray response
      do_reset(3, 3);
      go();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      chk_reset_outs("rst6");
      force_resp = 1'b1;
      go();
      chk("t6_req_valid", {31'd0, s_rv}, 32'd1);
      chk("t6_req_addr", s_addr, 32'h0);
      chk("t6_stray_valid", {31'd0, d_valid}, 32'd0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         go();
         if (d_valid) found = 1'b1;
      end
      chk("t6_deliver_seen", {31'd0, found}, 32'd1);
      chk("t6_pc", d_pc, 32'h0);
      chk("t6_instr", d_instr, 32'hA5);

      // randomized hazards, latencies and redirects
      do_reset(1, 4);
      base = delivered;
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(99, 0));
         if ($urandom_range(3, 0) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
         else t = $urandom();
         cyc(1'b0, $urandom_range(99, 0) < 15, $urandom_range(99, 0) < 20,
             r < 4, t, $urandom_range(9, 0) < 7);
      end
      chk("rand_progress", {31'd0, (delivered - base) > 200}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the fetch PC and the instruction-memory request/response handshake, and drives the F/D pipeline register.
- Consumes the stall, flush and redirect signals from the hazard block and the execute-stage branch outcome.
- Tolerates variable-latency instruction memory: at most one request outstanding, plus a 1-entry hold buffer for responses that arrive while decode is stalled.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0013, encoding loaded into F/D on bubble/flush (addi x0,x0,0)

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  synchronous, active-high reset
i_f_stall  in  1  hazard: freeze PC / suppress new requests
i_fd_stall  in  1  hazard: hold F/D register
i_fd_flush  in  1  hazard: load bubble into F/D
i_e_mux_pc_src  in  1  execute: redirect taken
i_e_pc_target  in  32  execute: redirect address
o_imem_req_valid  out  1  request valid
o_imem_req_addr  out  32  request address (word aligned)
i_imem_req_ready  in  1  memory accepts request
i_imem_resp_valid  in  1  response data valid
i_imem_resp_data  in  32  instruction word
o_d_instr  out  32  F/D instruction
o_d_pc  out  32  F/D PC
o_d_pc_plus4  out  32  F/D PC+4
o_d_valid  out  1  F/D holds a real instruction

Behaviour:
- Reset (i_reset=1 at edge):
  - pc_f=RESET_PC, state=REQ, hold buffer empty.
  - o_d_instr=NOP_INSTR, o_d_pc=0, o_d_pc_plus4=0, o_d_valid=0.
  - o_imem_req_valid=0 while i_reset is high.
- States:
  - REQ: o_imem_req_valid=~i_f_stall, addr=pc_f. Accept (valid&ready) -> WAIT. Any i_imem_resp_valid seen in REQ is spurious and ignored.
  - WAIT: one request outstanding, awaiting response.
  - HOLD: response captured, F/D stalled.
  - DROP: outstanding response belongs to a squashed path.
- deliver = instruction available (WAIT&resp_valid, or HOLD) & ~i_fd_stall & ~i_fd_flush & ~redirect.
- F/D update priority: i_fd_flush or redirect -> NOP_INSTR, valid=0; else i_fd_stall -> hold; else deliver -> {resp/hold data, address, address+4}, valid=1; else bubble (NOP_INSTR, valid=0).
- On deliver: pc_f <= pc_f+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0).
- Back-to-back issue from WAIT:
  - When the response is delivered, o_imem_req_valid=~i_f_stall with addr=pc_f+4 in the same cycle (combinational resp_valid -> req_valid path is allowed).
  - Accepted -> stay WAIT; otherwise -> REQ.
  - With a ready=1, 1-cycle memory this sustains 1 instr/cycle.
- WAIT & resp_valid & i_fd_stall & ~redirect: capture into the hold buffer -> HOLD. No requests are issued in HOLD. HOLD -> deliver when i_fd_stall drops, then -> REQ.
- Redirect (i_e_mux_pc_src=1) has priority over all stalls:
  - pc_f <= i_e_pc_target.
  - REQ: the unaccepted request may change address; the new address is driven next cycle.
  - WAIT without resp_valid -> DROP.
  - WAIT with resp_valid in the same cycle -> response discarded -> REQ.
  - HOLD -> buffer cleared -> REQ.
  - DROP -> stay DROP.
- DROP: the next resp_valid is discarded -> REQ. A new redirect in DROP only updates pc_f.
- Request address stability: the address may change while valid&~ready only due to redirect. Otherwise it is held stable until accepted.
- i_e_pc_target[1:0] is ignored (forced to 0).

Test Plan:
- RESET_PC=0; memory ready=1, 1-cycle response, data=addr^0xA5 -> req addrs 0,4,8,… on consecutive cycles; first o_d_valid=1 (pc 0, pc_plus4 4) two edges after reset release, then one instruction per cycle.
- i_fd_stall=i_f_stall=1 for 3 cycles while the response for 0x8 arrives:
  - F/D holds pc 0x4 and the state is HOLD, with no requests issued.
  - The first edge after release shows pc 0x8 with valid=1.
  - The next request is to 0xC.
- 3-cycle memory latency; redirect to 0x100 one cycle after request 0x10 is accepted:
  - F/D valid=0, DROP; the 0x10 response is discarded.
  - The next request is 0x100, and F/D next shows pc 0x100.
- Redirect to 0x200 in the same cycle that the response arrives -> response discarded, F/D valid=0, next request 0x200.
- i_imem_req_ready=0 for 4 cycles at pc 0x20 -> req_valid=1, addr stays 0x20; F/D bubbles (NOP, valid=0) each cycle.
- Reset asserted in WAIT, then a stray resp_valid one cycle after release -> all outputs return to reset values, the stray response is ignored, and the first request is RESET_PC.
